// File: rtl/calculator_axil_slave.sv
// AXI4-Lite calculator slave: operand/control register file plus an execution engine
// running add, sub, mul (one cycle) and a 32-cycle restoring unsigned divide.
module calculator_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              irq
);

    // state | meaning
    // IDLE  | waiting for a start; RESULT/STATUS hold last completion
    // EXEC  | operation running on shadow operands, busy=1
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] OP_ADD      = 2'b00;
    localparam logic [1:0] OP_SUB      = 2'b01;
    localparam logic [1:0] OP_MUL      = 2'b10;
    localparam logic [1:0] OP_DIV      = 2'b11;

    // Register file
    logic [31:0] opa;
    logic [31:0] opb;
    logic [1:0]  ctrl_op;
    logic        ctrl_ie;
    logic [31:0] result;
    logic        done;
    logic        div_by_zero;
    logic        busy;

    // Write channel latches
    logic        aw_latched;
    logic [2:0]  aw_idx;
    logic        w_latched;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        bvalid;
    logic [1:0]  bresp;

    logic        aw_hs;
    logic        w_hs;
    logic        commit;
    logic [31:0] opa_merged;
    logic [31:0] opb_merged;
    logic [31:0] ctrl_merged;
    logic        start_req;

    // Read channel
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [2:0]  ar_idx;
    logic [31:0] rd_mux;
    logic [1:0]  rd_resp;

    // Engine
    state_t      state_q;
    state_t      state_d;
    logic [1:0]  sh_op;
    logic [31:0] sh_a;
    logic [31:0] sh_b;
    logic [4:0]  div_cnt;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] alu_out;
    logic        exec_last;

    logic        unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return m;
    endfunction

    // Readies are gated by reset so every output reads 0 while ARESET is high.
    assign S_AXI_AWREADY = ~ARESET & ~aw_latched & ~bvalid;
    assign S_AXI_WREADY  = ~ARESET & ~w_latched & ~bvalid;
    assign S_AXI_ARREADY = ~ARESET & ~rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign irq           = done & ctrl_ie;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign commit = aw_latched & w_latched & ~bvalid;

    assign opa_merged  = merge_bytes(opa, w_data, w_strb);
    assign opb_merged  = merge_bytes(opb, w_data, w_strb);
    assign ctrl_merged = merge_bytes({29'b0, ctrl_ie, ctrl_op}, w_data, w_strb);
    assign start_req   = commit & (aw_idx == 3'd2) & w_strb[3] & w_data[31];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_latched <= 1'b0;
            aw_idx     <= 3'd0;
            w_latched  <= 1'b0;
            w_data     <= 32'h0;
            w_strb     <= 4'h0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            opa        <= 32'h0;
            opb        <= 32'h0;
            ctrl_op    <= 2'b00;
            ctrl_ie    <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_latched <= 1'b1;
                aw_idx     <= S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
                w_latched <= 1'b1;
                w_data    <= S_AXI_WDATA;
                w_strb    <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= RESP_OKAY;
                case (aw_idx)
                    3'd0: opa <= opa_merged;
                    3'd1: opb <= opb_merged;
                    3'd2: begin
                        ctrl_op <= ctrl_merged[1:0];
                        ctrl_ie <= ctrl_merged[2];
                    end
                    default: bresp <= RESP_SLVERR;
                endcase
            end
            if (bvalid && S_AXI_BREADY) begin
                bvalid     <= 1'b0;
                aw_latched <= 1'b0;
                w_latched  <= 1'b0;
            end
        end
    end

    assign ar_idx = S_AXI_ARADDR[4:2];

    always_comb begin
        rd_mux  = 32'h0;
        rd_resp = RESP_OKAY;
        case (ar_idx)
            3'd0:    rd_mux = opa;
            3'd1:    rd_mux = opb;
            3'd2:    rd_mux = {29'b0, ctrl_ie, ctrl_op};
            3'd3:    rd_mux = result;
            3'd4:    rd_mux = {29'b0, div_by_zero, done, busy};
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid <= 1'b0;
            rdata  <= 32'h0;
            rresp  <= RESP_OKAY;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
            rresp  <= rd_resp;
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {div_rem, div_quo[31]};
    assign rem_sub   = rem_shift - {1'b0, sh_b};
    assign rem_next  = rem_sub[32] ? rem_shift[31:0] : rem_sub[31:0];
    assign quo_next  = {div_quo[30:0], ~rem_sub[32]};

    always_comb begin
        alu_out = 32'h0;
        case (sh_op)
            OP_ADD:  alu_out = sh_a + sh_b;
            OP_SUB:  alu_out = sh_a - sh_b;
            OP_MUL:  alu_out = sh_a * sh_b;
            default: alu_out = 32'h0;
        endcase
    end

    assign busy      = (state_q == EXEC);
    assign exec_last = (sh_op != OP_DIV) || (sh_b == 32'h0) || (div_cnt == 5'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req) state_d = EXEC;
            EXEC:    if (exec_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sh_op       <= OP_ADD;
            sh_a        <= 32'h0;
            sh_b        <= 32'h0;
            div_cnt     <= 5'd0;
            div_rem     <= 32'h0;
            div_quo     <= 32'h0;
            result      <= 32'h0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start_req) begin
                sh_op       <= ctrl_merged[1:0];
                sh_a        <= opa;
                sh_b        <= opb;
                div_cnt     <= 5'd31;
                div_rem     <= 32'h0;
                div_quo     <= opa;
                done        <= 1'b0;
                div_by_zero <= 1'b0;
            end
        end else begin
            if (sh_op == OP_DIV) begin
                if (sh_b == 32'h0) begin
                    result      <= 32'hFFFF_FFFF;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end else begin
                    div_rem <= rem_next;
                    div_quo <= quo_next;
                    div_cnt <= div_cnt - 5'd1;
                    if (div_cnt == 5'd0) begin
                        result <= quo_next;
                        done   <= 1'b1;
                    end
                end
            end else begin
                result <= alu_out;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calculator_axil_slave.sv
// Directed bench for calculator_axil_slave: register access, all four operations,
// write/read channel corners and asynchronous reset in the middle of a divide.
module tb_calculator_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        irq;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int busy_total = 0;

    calculator_axil_slave dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .irq           (irq)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) if (dut.busy) busy_total++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay,
                             input int b_hold, output logic [1:0] resp);
        int  n;
        bit  aw_done, w_done, aw_acc, w_acc;
        @(negedge ACLK);
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_WVALID  = 1'b1;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = (aw_delay == 0);
        S_AXI_BREADY  = (b_hold == 0);
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 40) begin
            aw_acc = S_AXI_AWVALID && S_AXI_AWREADY;
            w_acc  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge ACLK);
            n++;
            if (aw_acc) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (w_acc)  begin S_AXI_WVALID  = 1'b0; w_done  = 1; end
            if (!aw_done && n >= aw_delay) S_AXI_AWVALID = 1'b1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("aw_w_accepted", {30'b0, aw_done, w_done}, 32'h3);
        while (!S_AXI_BVALID && n < 80) begin
            @(negedge ACLK);
            n++;
        end
        check("bvalid_seen", {31'b0, S_AXI_BVALID}, 32'h1);
        for (int i = 0; i < b_hold; i++) begin
            check("bvalid_held", {31'b0, S_AXI_BVALID}, 32'h1);
            check("aw_w_ready_low", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h0);
            @(negedge ACLK);
        end
        S_AXI_BREADY = 1'b1;
        resp = S_AXI_BRESP;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check("bvalid_single", {31'b0, S_AXI_BVALID}, 32'h0);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        bit acc;
        @(negedge ACLK);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 40) begin
            acc = S_AXI_ARREADY;
            @(negedge ACLK);
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        while (!S_AXI_RVALID && n < 80) begin
            @(negedge ACLK);
            n++;
        end
        check("rvalid_seen", {31'b0, S_AXI_RVALID}, 32'h1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        @(negedge ACLK);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, 0, 0, r);
        check($sformatf("bresp@%02h", addr), {30'b0, r}, {30'b0, exp_resp});
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check($sformatf("rdata@%02h", addr), d, exp_data);
        check($sformatf("rresp@%02h", addr), {30'b0, r}, {30'b0, exp_resp});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (dut.busy && n < 60) begin
            @(negedge ACLK);
            n++;
        end
        check("engine_idle", {31'b0, dut.busy}, 32'h0);
    endtask

    initial begin
        logic [1:0] r;
        int mark;

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_ready", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
        check("rst_valid_irq", {29'b0, S_AXI_BVALID, S_AXI_RVALID, irq}, 32'h0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("idle_ready", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
        rd(5'h0C, 32'h0, OKAY);

        // register read-back
        wr(5'h00, 32'h1, OKAY);
        wr(5'h04, 32'h2, OKAY);
        wr(5'h08, 32'h4, OKAY);
        rd(5'h00, 32'h1, OKAY);
        rd(5'h04, 32'h2, OKAY);
        rd(5'h08, 32'h4, OKAY);

        // add: 7 + 5
        wr(5'h00, 32'd7, OKAY);
        wr(5'h04, 32'd5, OKAY);
        mark = busy_total;
        wr(5'h08, 32'h8000_0000, OKAY);
        wait_idle();
        check("add_busy_cycles", busy_total - mark, 32'd1);
        rd(5'h0C, 32'd12, OKAY);
        rd(5'h10, 32'h2, OKAY);
        rd(5'h08, 32'h0, OKAY);

        // sub: 7 - 9
        wr(5'h04, 32'd9, OKAY);
        mark = busy_total;
        wr(5'h08, 32'h8000_0001, OKAY);
        wait_idle();
        check("sub_busy_cycles", busy_total - mark, 32'd1);
        rd(5'h0C, 32'hFFFF_FFFE, OKAY);

        // mul low word: 0x10000 * 0x10003 = 0x1_0003_0000
        wr(5'h00, 32'h0001_0000, OKAY);
        wr(5'h04, 32'h0001_0003, OKAY);
        wr(5'h08, 32'h8000_0002, OKAY);
        wait_idle();
        rd(5'h0C, 32'h0003_0000, OKAY);

        // div 100 / 7 with an ignored restart mid-run
        wr(5'h00, 32'd100, OKAY);
        wr(5'h04, 32'd7, OKAY);
        mark = busy_total;
        wr(5'h08, 32'h8000_0003, OKAY);
        rd(5'h10, 32'h1, OKAY);
        wr(5'h00, 32'd1, OKAY);
        wr(5'h08, 32'h8000_0003, OKAY);
        wait_idle();
        check("div_busy_cycles", busy_total - mark, 32'd32);
        rd(5'h0C, 32'd14, OKAY);
        rd(5'h10, 32'h2, OKAY);
        rd(5'h00, 32'd1, OKAY);
        repeat (5) @(negedge ACLK);
        rd(5'h0C, 32'd14, OKAY);

        // divide by zero with interrupt enabled (OPA=1, OPB=0)
        wr(5'h04, 32'd0, OKAY);
        mark = busy_total;
        wr(5'h08, 32'h8000_0007, OKAY);
        wait_idle();
        check("dbz_busy_cycles", busy_total - mark, 32'd1);
        rd(5'h0C, 32'hFFFF_FFFF, OKAY);
        rd(5'h10, 32'h6, OKAY);
        check("irq_dbz", {31'b0, irq}, 32'h1);

        // add with ie=0 clears div_by_zero and irq: 1 + 0
        wr(5'h08, 32'h8000_0000, OKAY);
        wait_idle();
        rd(5'h0C, 32'd1, OKAY);
        rd(5'h10, 32'h2, OKAY);
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // W leads AW by three cycles
        axi_write(5'h00, 32'hA5A5_0001, 4'hF, 3, 0, r);
        check("w_first_bresp", {30'b0, r}, {30'b0, OKAY});
        rd(5'h00, 32'hA5A5_0001, OKAY);

        // byte strobes; start bit without WSTRB[3] does nothing
        axi_write(5'h00, 32'h1234_FFFF, 4'h3, 0, 0, r);
        rd(5'h00, 32'hA5A5_FFFF, OKAY);
        axi_write(5'h08, 32'h8000_0006, 4'h1, 0, 0, r);
        check("strb_ctrl_bresp", {30'b0, r}, {30'b0, OKAY});
        rd(5'h08, 32'h6, OKAY);
        rd(5'h10, 32'h2, OKAY);
        rd(5'h0C, 32'd1, OKAY);
        check("irq_ie_set", {31'b0, irq}, 32'h1);

        // BREADY held low for five cycles
        axi_write(5'h04, 32'h33, 4'hF, 0, 5, r);
        check("bhold_bresp", {30'b0, r}, {30'b0, OKAY});
        rd(5'h04, 32'h33, OKAY);

        // read-only and unmapped writes
        wr(5'h0C, 32'hDEAD, SLVERR);
        rd(5'h0C, 32'd1, OKAY);
        wr(5'h10, 32'h0, SLVERR);
        rd(5'h10, 32'h2, OKAY);
        wr(5'h14, 32'h8000_0000, SLVERR);
        rd(5'h00, 32'hA5A5_FFFF, OKAY);
        rd(5'h08, 32'h6, OKAY);
        rd(5'h10, 32'h2, OKAY);
        rd(5'h18, 32'h0, SLVERR);

        // reset in the middle of a divide with RVALID pending
        wr(5'h00, 32'd100, OKAY);
        wr(5'h04, 32'd7, OKAY);
        wr(5'h08, 32'h8000_0007, OKAY);
        check("div_running", {31'b0, dut.busy}, 32'h1);
        @(negedge ACLK);
        S_AXI_ARADDR  = 5'h00;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        check("rvalid_pending", {31'b0, S_AXI_RVALID}, 32'h1);
        ARESET = 1'b1;
        #1;
        check("arst_ready", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
        check("arst_valid_irq", {29'b0, S_AXI_BVALID, S_AXI_RVALID, irq}, 32'h0);
        check("arst_rdata", S_AXI_RDATA, 32'h0);
        check("arst_resp", {28'b0, S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
        check("arst_busy", {31'b0, dut.busy}, 32'h0);
        @(negedge ACLK);
        ARESET = 1'b0;
        rd(5'h00, 32'h0, OKAY);
        rd(5'h04, 32'h0, OKAY);
        rd(5'h08, 32'h0, OKAY);
        rd(5'h0C, 32'h0, OKAY);
        rd(5'h10, 32'h0, OKAY);

        // normal add after reset: 3 + 4
        wr(5'h00, 32'd3, OKAY);
        wr(5'h04, 32'd4, OKAY);
        wr(5'h08, 32'h8000_0000, OKAY);
        wait_idle();
        rd(5'h0C, 32'd7, OKAY);
        rd(5'h10, 32'h2, OKAY);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/calculator_axil_slave.md
Name: calculator_axil_slave

Overview:
AXI4-Lite slave (responder) that implements the calculator register file and its execution engine. It is the endpoint that the AXI4-Lite master VIP, and later the Zynq PS GP port, drives with single-beat reads and writes. It holds two operand registers, a control register with a start trigger, and read-only result and status registers. The execution engine runs add, subtract, multiply (single cycle) and unsigned divide (multi-cycle, restoring).

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus and operand width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  5  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  5  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
irq  out  1  level interrupt: STATUS.done & CTRL.ie

Behaviour:
- Register map (word address = ADDR[4:2]):
  - 0x00 OPA: RW.
  - 0x04 OPB: RW.
  - 0x08 CTRL: RW. [1:0] op (00 add, 01 sub, 10 mul low 32 bits, 11 unsigned div); [2] ie. [31] start: write-1 triggers, self-clearing, always reads 0. Other bits read 0.
  - 0x0C RESULT: RO.
  - 0x10 STATUS: RO. [0] busy, [1] done, [2] div_by_zero.
  - 0x14–0x1C: unmapped.
- Reset: all outputs and registers go to 0, including READY, VALID, BRESP, RRESP, RDATA and irq. The engine returns to IDLE. This applies at any time, including mid-divide, mid-handshake, or while BVALID or RVALID is pending.
- Write channel:
  - AW and W are accepted independently, in either order or in the same cycle.
  - AWREADY is high while no address is latched and BVALID=0; WREADY follows the same rule for data.
  - Once both address and data are latched, the write commits in that cycle and BVALID rises on the next edge.
  - BVALID is held until BREADY, and both latches clear on the B handshake.
  - Only one write is outstanding at a time.
- WSTRB is honoured per byte on OPA, OPB and CTRL. The start bit takes effect only if WSTRB[3]=1.
- BRESP:
  - OKAY for 0x00–0x08.
  - SLVERR for writes to 0x0C or 0x10; no register changes.
  - SLVERR for unmapped addresses; no register changes.
- Read channel:
  - ARREADY is high when RVALID=0.
  - The AR handshake registers RDATA and RRESP, and RVALID rises the next cycle. RVALID is held until RREADY.
  - Unmapped reads return 0 with SLVERR; all mapped reads return OKAY.
- Simultaneous read and write: both are serviced independently. A read in the commit cycle returns the pre-write value.
- Engine FSM: IDLE -> EXEC -> IDLE.
  - Start in IDLE: OPA, OPB and op are copied into internal shadow registers, done and div_by_zero clear, and the FSM enters EXEC with busy=1 on the next cycle.
  - Add, sub and mul: EXEC lasts 1 cycle. Arithmetic is modulo 2^32; mul keeps the low 32 bits of the unsigned product.
  - Div: EXEC lasts 32 cycles, restoring, one quotient bit per cycle. RESULT is the quotient; the remainder is discarded.
  - Div with OPB=0: EXEC lasts 1 cycle, RESULT=0xFFFFFFFF, div_by_zero=1.
  - On leaving EXEC: RESULT updates, busy=0, done=1 in the same edge.
- done is sticky until the next accepted start.
- Start while busy: ignored, BRESP OKAY. The op and ie fields of CTRL still update. The running operation is unaffected.
- Writes to OPA and OPB while busy update the registers but not the running operation (it uses the shadow copies).
- RESULT holds its last value until the next completion.

Test Plan:
- Write OPA=0x1, OPB=0x2, CTRL=0x4 and read back -> 0x1, 0x2, 0x4, all OKAY. Read 0x0C after reset -> 0x0.
- OPA=7, OPB=5, CTRL=0x80000000 (add) -> busy=1 for 1 cycle, then RESULT=12 and STATUS=0x2. Repeat with sub and OPB=9 -> RESULT=0xFFFFFFFE.
- OPA=100, OPB=7, CTRL=0x80000003 -> busy high exactly 32 cycles, RESULT=14, done=1. A start issued mid-run with OPA=1 is ignored and RESULT is still 14.
- OPB=0 with div, ie=1 -> RESULT=0xFFFFFFFF, STATUS=0x6, irq=1. A new add start clears irq and div_by_zero.
- Protocol corners:
  - W leads AW by 3 cycles -> single commit.
  - BREADY held low 5 cycles -> BVALID held and AWREADY/WREADY stay low.
  - Write 0x0C or 0x14 -> SLVERR and no state change.
  - Read 0x18 -> 0x0 with SLVERR.
- Assert ARESET for 1 cycle mid-divide with RVALID pending -> all outputs 0 immediately and all registers 0. A subsequent add works normally.
